pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Controller that owns the program counter and selects the next fetch address each cycle.
- Sources: sequential increment, branch, jump, trap vector, trap return. Also handles stall, halt/resume and a registered flush pulse.
- Sits between the decode/execute control signals and the instruction-memory address input. Replaces the free-running PC register plus incrementer pair.
- Addresses are word-indexed; sequential step is +1.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_PC, 0, value loaded into pc_out on reset.
- TRAP_VECTOR, 16, handler entry address loaded on an accepted trap.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC this cycle; sequential advance only.
- branch_taken  input  1  take branch_target this cycle.
- branch_target  input  WIDTH  branch destination.
- jump  input  1  take jump_target this cycle.
- jump_target  input  WIDTH  jump destination.
- trap_req  input  1  request entry to trap handler.
- eret  input  1  return from trap handler.
- halt  input  1  enter halted state.
- resume  input  1  leave halted state.
- pc_out  output  WIDTH  current fetch address (registered).
- flush  output  1  one-cycle pulse: pc_out was just redirected; discard the in-flight instruction.
- epc  output  WIDTH  saved return address.
- in_trap  output  1  handler active; no nesting.
- halted  output  1  sequencer is in HALTED.

Behaviour:
- Reset:
  - rst=1 at a rising edge sets pc_out=RESET_PC, epc=0, flush=0, in_trap=0, halted=0, state=RUN.
  - rst overrides every other input, in any state, mid-operation included.
- All outputs are registered. Every decision made at edge N is visible after edge N.
- States: RUN, HALTED. in_trap is an orthogonal flag.
- RUN, evaluated in strict priority order each cycle:
  1. trap_req & !in_trap: epc<=pc_out+1; pc_out<=TRAP_VECTOR; in_trap<=1; flush<=1.
  2. eret & in_trap: pc_out<=epc; in_trap<=0; flush<=1.
  3. jump: pc_out<=jump_target; flush<=1.
  4. branch_taken: pc_out<=branch_target; flush<=1.
  5. halt: state<=HALTED; halted<=1; pc_out held; flush<=0.
  6. stall: pc_out held; flush<=0.
  7. otherwise: pc_out<=pc_out+1; flush<=0.
- Cases that fall through to lower priority:
  - trap_req while in_trap=1 is ignored and evaluation continues at item 2.
  - eret while in_trap=0 is ignored and evaluation continues at item 3.
- Redirects (items 1-4) take effect even when stall=1. stall only blocks sequential advance and halt entry is unaffected.
- jump and branch_taken together: jump wins.
- flush is high for exactly one cycle per redirect, coincident with the new pc_out. Back-to-back redirects keep flush high on consecutive cycles.
- HALTED:
  - pc_out is held and flush=0.
  - trap_req (with in_trap=0) is accepted exactly as in RUN: epc<=pc_out+1, pc_out<=TRAP_VECTOR, flush<=1, state<=RUN, halted<=0.
  - Otherwise, resume leads to state<=RUN, halted<=0, pc_out<=pc_out+1.
  - All other inputs (jump, branch, eret, stall, halt) are ignored.
- Arithmetic: every +1 is modulo 2^WIDTH; all-ones wraps to 0 with no flag. epc capture wraps the same way.
- epc changes only on an accepted trap and on reset.

Test Plan:
- Reset then 4 idle cycles: pc_out = 0,1,2,3,4; flush=0 throughout; rst asserted at pc=4 returns pc_out=0 next cycle.
- At pc_out=5, assert jump=1 (jump_target=0x40) and branch_taken=1 (target 0x80) together with stall=1: next pc_out=0x40, flush=1 for one cycle; next cycle with no inputs gives pc_out=0x41, flush=0.
- At pc_out=7, assert trap_req: pc_out=16, epc=8, in_trap=1, flush=1. A second trap_req at pc=17 is ignored (pc_out=18). Then eret gives pc_out=8, in_trap=0, flush=1.
- At pc_out=3, assert halt: pc_out holds 3 and halted=1 for 5 cycles, with jump and stall ignored. Then resume gives pc_out=4, halted=0.
- While halted at pc_out=9, assert trap_req: pc_out=16, epc=10, halted=0, in_trap=1, flush=1.
- Set jump_target=0xFFFFFFFF, then run idle: pc_out goes 0xFFFFFFFF, then 0. A trap taken at 0xFFFFFFFF gives epc=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch address from increment, branch,
// jump, trap entry and trap return, with stall, halt/resume and a registered flush pulse.
module pc_sequencer #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_PC    = '0,
    parameter logic [WIDTH-1:0]      TRAP_VECTOR = WIDTH'(16)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             trap_req,
    input  logic             eret,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc_out,
    output logic             flush,
    output logic [WIDTH-1:0] epc,
    output logic             in_trap,
    output logic             halted
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             in_trap_q, in_trap_d;
    logic             flush_q, flush_d;
    logic [WIDTH-1:0] pc_inc;
    logic             trap_ok;

    // Increment wraps naturally at WIDTH bits; epc capture uses the same value.
    assign pc_inc  = pc_q + WIDTH'(1);
    assign trap_ok = trap_req & ~in_trap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            in_trap_q <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            in_trap_q <= in_trap_d;
            flush_q   <= flush_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        in_trap_d = in_trap_q;
        flush_d   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                // Ignored trap/eret fall through to the next priority level.
                if (trap_ok) begin
                    epc_d     = pc_inc;
                    pc_d      = TRAP_VECTOR;
                    in_trap_d = 1'b1;
                    flush_d   = 1'b1;
                end else if (eret && in_trap_q) begin
                    pc_d      = epc_q;
                    in_trap_d = 1'b0;
                    flush_d   = 1'b1;
                end else if (jump) begin
                    pc_d    = jump_target;
                    flush_d = 1'b1;
                end else if (branch_taken) begin
                    pc_d    = branch_target;
                    flush_d = 1'b1;
                end else if (halt) begin
                    state_d = ST_HALTED;
                end else if (!stall) begin
                    pc_d = pc_inc;
                end
            end
            ST_HALTED: begin
                if (trap_ok) begin
                    epc_d     = pc_inc;
                    pc_d      = TRAP_VECTOR;
                    in_trap_d = 1'b1;
                    flush_d   = 1'b1;
                    state_d   = ST_RUN;
                end else if (resume) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_out  = pc_q;
        epc     = epc_q;
        in_trap = in_trap_q;
        flush   = flush_q;
        halted  = (state_q == ST_HALTED);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: linear stimulus with hand-computed expectations
// checked by immediate assertions one time unit after each rising edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump, trap_req, eret, halt, resume;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_out, epc;
    logic        flush, in_trap, halted;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    pc_sequencer #(
        .WIDTH(32),
        .RESET_PC(32'h0),
        .TRAP_VECTOR(32'd16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_target(jump_target),
        .trap_req(trap_req),
        .eret(eret),
        .halt(halt),
        .resume(resume),
        .pc_out(pc_out),
        .flush(flush),
        .epc(epc),
        .in_trap(in_trap),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; stall = 0; branch_taken = 0; jump = 0;
        trap_req = 0; eret = 0; halt = 0; resume = 0;
        branch_target = '0; jump_target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [31:0] tgt);
        idle(); jump = 1; jump_target = tgt;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        check("rst_pc", pc_out, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_in_trap", {31'b0, in_trap}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        rst = 0;

        for (int i = 1; i <= 4; i++) begin
            tick();
            check("seq_pc", pc_out, 32'(i));
            check("seq_flush", {31'b0, flush}, 32'h0);
        end
        rst = 1;
        tick();
        check("rst_mid_pc", pc_out, 32'h0);
        rst = 0;

        for (int i = 0; i < 5; i++) tick();
        check("pre_jump_pc", pc_out, 32'h5);
        jump = 1; jump_target = 32'h40; branch_taken = 1; branch_target = 32'h80; stall = 1;
        tick();
        check("jump_wins_pc", pc_out, 32'h40);
        check("jump_flush", {31'b0, flush}, 32'h1);
        idle();
        tick();
        check("after_jump_pc", pc_out, 32'h41);
        check("after_jump_flush", {31'b0, flush}, 32'h0);

        branch_taken = 1; branch_target = 32'h90; stall = 1;
        tick();
        check("branch_pc", pc_out, 32'h90);
        check("branch_flush", {31'b0, flush}, 32'h1);
        idle(); stall = 1;
        tick();
        check("stall_pc", pc_out, 32'h90);
        check("stall_flush", {31'b0, flush}, 32'h0);

        jump_to(32'h7);
        trap_req = 1;
        tick();
        check("trap_pc", pc_out, 32'd16);
        check("trap_epc", epc, 32'h8);
        check("trap_in_trap", {31'b0, in_trap}, 32'h1);
        check("trap_flush", {31'b0, flush}, 32'h1);
        idle();
        tick();
        check("handler_pc", pc_out, 32'd17);
        trap_req = 1;
        tick();
        check("nested_trap_pc", pc_out, 32'd18);
        check("nested_trap_epc", epc, 32'h8);
        check("nested_trap_flush", {31'b0, flush}, 32'h0);
        idle(); eret = 1; jump = 1; jump_target = 32'h33;
        tick();
        check("eret_pc", pc_out, 32'h8);
        check("eret_in_trap", {31'b0, in_trap}, 32'h0);
        check("eret_flush", {31'b0, flush}, 32'h1);
        idle(); eret = 1;
        tick();
        check("stray_eret_pc", pc_out, 32'h9);
        check("stray_eret_flush", {31'b0, flush}, 32'h0);

        jump_to(32'h3);
        halt = 1; stall = 1;
        tick();
        check("halt_pc", pc_out, 32'h3);
        check("halt_halted", {31'b0, halted}, 32'h1);
        check("halt_flush", {31'b0, flush}, 32'h0);
        idle(); jump = 1; jump_target = 32'h55; stall = 1; eret = 1; branch_taken = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halted_hold_pc", pc_out, 32'h3);
            check("halted_hold_flag", {31'b0, halted}, 32'h1);
            check("halted_hold_flush", {31'b0, flush}, 32'h0);
        end
        idle(); resume = 1;
        tick();
        check("resume_pc", pc_out, 32'h4);
        check("resume_halted", {31'b0, halted}, 32'h0);
        idle();

        jump_to(32'h9);
        halt = 1;
        tick();
        check("halt2_halted", {31'b0, halted}, 32'h1);
        idle(); trap_req = 1; resume = 1;
        tick();
        check("halted_trap_pc", pc_out, 32'd16);
        check("halted_trap_epc", epc, 32'd10);
        check("halted_trap_halted", {31'b0, halted}, 32'h0);
        check("halted_trap_in_trap", {31'b0, in_trap}, 32'h1);
        check("halted_trap_flush", {31'b0, flush}, 32'h1);
        idle(); eret = 1;
        tick();
        check("eret2_pc", pc_out, 32'd10);
        idle();

        jump_to(32'hFFFF_FFFF);
        check("wrap_top_pc", pc_out, 32'hFFFF_FFFF);
        tick();
        check("wrap_pc", pc_out, 32'h0);
        jump_to(32'hFFFF_FFFF);
        trap_req = 1;
        tick();
        check("wrap_trap_epc", epc, 32'h0);
        check("wrap_trap_pc", pc_out, 32'd16);
        idle(); rst = 1;
        tick();
        check("rst_in_trap_clear", {31'b0, in_trap}, 32'h0);
        check("rst_epc_clear", epc, 32'h0);
        check("rst_pc_again", pc_out, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
